rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Writeback stage directly upstream of the 32x32 register file. Merges two result sources into the file's single write port (w_data/w_addr/w_ena):
- the ALU result, which is never back-pressured;
- the memory-load return, which uses valid/ready and is buffered in a small FIFO.

It also keeps a pending-load scoreboard so the issue logic can stall on RAW/WAW hazards against outstanding loads, and bounds load starvation under continuous ALU traffic.

Parameters:
DEPTH, 2, load-return FIFO entries; power of two, >=2
STARVE_LIMIT, 4, consecutive cycles the ALU may win while the FIFO is non-empty before a forced drain

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
mem_valid  input  1  load data offered
mem_ready  output  1  FIFO can accept; = (count < DEPTH) && !rst
mem_rd  input  5  load destination register
mem_data  input  32  load data
issue_load  input  1  load issued this cycle; marks issue_rd busy
issue_rd  input  5  destination of issued load
busy  output  32  scoreboard; bit r=1 means load to r outstanding; bit 0 always 0
alu_stall  output  1  registered; FIFO owns the write port next cycle
proto_err  output  1  sticky; alu_valid was asserted while alu_stall=1
w_data  output  32  registered write data to register file
w_addr  output  5  registered write address
w_ena  output  1  registered write enable

Behaviour:
- Reset values: w_ena=0, w_addr=0, w_data=0, busy=0, alu_stall=0, proto_err=0, FIFO empty, starvation counter=0. Reset asserted mid-transfer discards FIFO contents and all pending busy bits.
- Per-cycle arbitration, decided combinationally; the result is registered onto w_*, so the register file sees it one cycle later.
  - alu_stall=1: FIFO head wins and pops. Any alu_valid that cycle is dropped and proto_err is set.
  - Else alu_valid=1 and alu_rd!=0: ALU wins and the FIFO holds.
  - Else alu_valid=1 and alu_rd=0: no ALU write. The FIFO may pop.
  - Else FIFO non-empty: head pops.
  - Else w_ena=0 next cycle. w_addr and w_data hold their previous values.
- Popped entry with rd=0: consumed but not written (w_ena=0).
- ALU latency: 1 cycle (alu_valid at edge N gives w_ena at N+1).
- Load latency: the pushed entry is not poppable in its push cycle. Minimum latency is 2 cycles from accept to w_ena.
- FIFO:
  - Push when mem_valid && mem_ready.
  - Push and pop in the same cycle are legal when non-empty.
  - mem_ready does not depend on same-cycle pop, so a full FIFO stays full-blocked for that cycle.
  - Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits wide.
  - Order is strict FIFO.
- Scoreboard:
  - Set bit issue_rd on issue_load when issue_rd!=0.
  - Clear bit r when an entry with rd=r pops.
  - Same-cycle set and clear of the same r: set wins.
  - Writes to x0 never set a bit.
  - An ALU write does not affect busy; preventing WAW against a busy register is the issue logic's job.
- Starvation:
  - Counter increments each cycle the ALU wins while the FIFO is non-empty.
  - Counter clears when the FIFO pops or becomes empty.
  - When the counter reaches STARVE_LIMIT, alu_stall=1 for exactly the next cycle. The counter clears on that pop.
- proto_err clears only on rst.

Decomposition:
- Package femto_rf_pkg holds:
  - XLEN=32, REG_AW=5, REG_ZERO=5'd0;
  - a wb_entry_t struct {rd[4:0], data[31:0]} shared with the register file and the issue logic.
- Sub-module rf_wb_fifo: parameterised synchronous FIFO with DEPTH, push/pop, full/empty/count, async active-high reset.
- Arbitration, scoreboard and starvation counter live in the top.

Test Plan:
- ALU-only: alu_valid=1, alu_rd=5, alu_data=0x1234_5678 at edge N -> w_ena=1, w_addr=5, w_data=0x12345678 at N+1. alu_rd=0 -> w_ena=0.
- Load path: issue_load rd=7 -> busy[7]=1. Then mem_valid with rd=7, data=0xDEADBEEF, ALU idle -> w_ena with addr 7 two cycles after accept; busy[7]=0 the cycle after the pop.
- Back-pressure: DEPTH=2, three back-to-back loads while ALU is busy every cycle -> mem_ready=0 after the second accept. Writes drain in order rd 1,2,3 with no loss.
- Starvation: FIFO holds one entry, ALU valid every cycle -> after 4 ALU wins, alu_stall=1 for one cycle and the load is written. ALU held off -> proto_err stays 0. ALU not held off -> that ALU write is dropped and proto_err=1.
- Scoreboard race: pop of rd=9 in the same cycle as issue_load rd=9 -> busy[9] remains 1. issue_load rd=0 -> busy stays 0.
- Reset mid-operation: FIFO full and busy=0x0000_0084, assert rst asynchronously -> immediately w_ena=0, busy=0, mem_ready=0. After release -> mem_ready=1 and no stale writes occur.

Source files
------------

// File: rtl/femto_rf_pkg.sv
// -----------------------------------------------------------------------------
// femto_rf_pkg
// Types and constants shared by the writeback stage, the register file and
// the issue logic.
//   XLEN       : datapath width
//   REG_AW     : register address width (32 architectural registers)
//   REG_ZERO   : x0, never written and never marked busy
//   wb_entry_t : one pending register write {rd, data}
//   reg_onehot : decode a register index into a 32-bit mask
// -----------------------------------------------------------------------------
package femto_rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// -----------------------------------------------------------------------------
// rf_wb_fifo
// Synchronous FIFO holding load returns until they win the register file
// write port. Pushes while full and pops while empty are ignored.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   i_push       : write i_push_data at the tail
//   i_pop        : drop the head entry
//   o_head       : current head entry (meaningful only when !o_empty)
//   o_full       : count == DEPTH
//   o_empty      : count == 0
//   o_count      : number of stored entries, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module rf_wb_fifo
  import femto_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_push_data,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Entry storage; slots are only read once counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Writeback stage in front of the 32x32 register file. Merges ALU results
// (never back-pressured) and buffered load returns onto one registered write
// port, tracks outstanding loads in a busy scoreboard, and forces a FIFO
// drain after STARVE_LIMIT consecutive ALU wins with loads waiting.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data     : ALU result
//   mem_valid/mem_ready/mem_rd/mem_data : load return handshake
//   issue_load/issue_rd           : load issued, marks issue_rd busy
//   busy                          : outstanding-load scoreboard (bit 0 = 0)
//   alu_stall                     : FIFO owns the write port this cycle
//   proto_err                     : sticky, ALU result offered during stall
//   w_data/w_addr/w_ena           : registered register-file write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter
  import femto_rf_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              issue_load,
  input  logic [REG_AW-1:0] issue_rd,
  output logic [XLEN-1:0]   busy,
  output logic              alu_stall,
  output logic              proto_err,
  output logic [XLEN-1:0]   w_data,
  output logic [REG_AW-1:0] w_addr,
  output logic              w_ena
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t          w_push_entry;
  wb_entry_t          w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic               w_alu_win;
  logic               w_wr_ena;
  logic [REG_AW-1:0]  w_wr_addr;
  logic [XLEN-1:0]    w_wr_data;
  logic [XLEN-1:0]    w_busy_set;
  logic [XLEN-1:0]    w_busy_clr;
  logic [XLEN-1:0]    w_busy_nxt;
  logic [SW-1:0]      r_starve;
  logic [SW-1:0]      w_starve_nxt;
  logic               w_stall_nxt;

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign mem_ready         = (w_count < CW'(DEPTH)) && !rst;
  assign w_push            = mem_valid && mem_ready && !w_full;
  assign w_push_entry.rd   = mem_rd;
  assign w_push_entry.data = mem_data;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Write-port arbitration; an entry pushed this cycle is not yet counted.
  always_comb begin
    w_alu_win = 1'b0;
    w_pop     = 1'b0;
    if (alu_stall) begin
      w_pop = !w_empty;
    end else if (alu_valid && (alu_rd != REG_ZERO)) begin
      w_alu_win = 1'b1;
    end else begin
      w_pop = !w_empty;
    end
  end

  // Next write-port values; address and data hold when nothing is written.
  always_comb begin
    w_wr_ena  = 1'b0;
    w_wr_addr = w_addr;
    w_wr_data = w_data;
    if (w_alu_win) begin
      w_wr_ena  = 1'b1;
      w_wr_addr = alu_rd;
      w_wr_data = alu_data;
    end else if (w_pop && (w_head.rd != REG_ZERO)) begin
      w_wr_ena  = 1'b1;
      w_wr_addr = w_head.rd;
      w_wr_data = w_head.data;
    end else begin
      w_wr_ena  = 1'b0;
    end
  end

  // Scoreboard update: set is applied after clear so a same-cycle issue wins.
  always_comb begin
    w_busy_set = 32'd0;
    w_busy_clr = 32'd0;
    if (issue_load && (issue_rd != REG_ZERO)) begin
      w_busy_set = reg_onehot(issue_rd);
    end else begin
      w_busy_set = 32'd0;
    end
    if (w_pop) begin
      w_busy_clr = reg_onehot(w_head.rd);
    end else begin
      w_busy_clr = 32'd0;
    end
    w_busy_nxt = ((busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
  end

  // Starvation counter: counts ALU wins over a waiting load, resets on drain.
  always_comb begin
    w_starve_nxt = r_starve;
    w_stall_nxt  = 1'b0;
    if (w_pop || w_empty) begin
      w_starve_nxt = SW'(0);
    end else if (w_alu_win) begin
      w_starve_nxt = r_starve + SW'(1);
      w_stall_nxt  = (w_starve_nxt == SW'(STARVE_LIMIT));
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Registered outputs and stage state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ena     <= 1'b0;
      w_addr    <= 5'd0;
      w_data    <= 32'd0;
      busy      <= 32'd0;
      alu_stall <= 1'b0;
      proto_err <= 1'b0;
      r_starve  <= SW'(0);
    end else begin
      w_ena     <= w_wr_ena;
      w_addr    <= w_wr_addr;
      w_data    <= w_wr_data;
      busy      <= w_busy_nxt;
      alu_stall <= w_stall_nxt;
      proto_err <= proto_err | (alu_stall & alu_valid);
      r_starve  <= w_starve_nxt;
    end
  end

endmodule
